// File: rtl/mandel_draw_pkg.sv
// Shared types and the iteration-count to shade mapping for the Mandelbrot pixel sink.
// Latency: combinational helper only; backpressure: not applicable.
package mandel_draw_pkg;

    localparam int MINLIMIT = 1;
    localparam int MAXLIMIT = 1000;
    localparam int NW       = $clog2(MAXLIMIT + 1);
    // Queued address field is sized for the largest frame we expect to drive.
    localparam int FB_AW    = 16;

    typedef enum logic [1:0] {
        ACTIVE,
        FINISHING,
        CLEARING
    } sink_state_e;

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [7:0]       shade;
    } pix_entry_t;

    function automatic logic [7:0] shade_map(input logic [NW-1:0] n);
        logic [NW:0] t;
        t = {1'b0, n} - (NW+1)'(MINLIMIT) + (NW+1)'(1);
        if (n == '0)
            shade_map = 8'd0;
        else if (n < NW'(MINLIMIT))
            shade_map = 8'd1;
        else if (t > (NW+1)'(255))
            shade_map = 8'hFF;
        else
            shade_map = t[7:0];
    endfunction

endpackage

// File: rtl/mandel_pix_fifo.sv
// Synchronous FIFO of pixel entries with full/empty flags.
// Latency: a push is visible at the head the following cycle; backpressure: push ignored when full.
module mandel_pix_fifo
    import mandel_draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       push_vld_i,
    input  pix_entry_t push_dat_i,
    input  logic       pop_rdy_i,
    output pix_entry_t pop_dat_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PW = $clog2(DEPTH);

    pix_entry_t      mem_q [DEPTH];
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;
    logic            do_push, do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop_dat_o = mem_q[rd_ptr_q[PW-1:0]];
    assign do_push   = push_vld_i && !full_o;
    assign do_pop    = pop_rdy_i && !empty_o;
    assign wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_ptr_q[PW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/mandel_pixel_sink.sv
// Draw-pixel sink: shades pixels, buffers them, writes the framebuffer; handles flush/finish/clear.
// Latency: >=1 cycle pixel to fb_we; backpressure: pix_ready low when FIFO full or not ACTIVE, writes stall on fb_ready.
module mandel_pixel_sink
    import mandel_draw_pkg::*;
#(
    parameter int WIDTH       = 200,
    parameter int HEIGHT      = 200,
    parameter int FLUSH_EVERY = 10,
    parameter int FIFO_DEPTH  = 4,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH * HEIGHT)
) (
    input  logic          sync_clk,
    input  logic          sync_rst_n,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [XW-1:0] pix_x,
    input  logic [YW-1:0] pix_y,
    input  logic [NW-1:0] pix_n,
    input  logic          frame_finish,
    input  logic          frame_clear,
    output logic          fb_we,
    input  logic          fb_ready,
    output logic [AW-1:0] fb_addr,
    output logic [7:0]    fb_data,
    output logic          flush,
    output logic          frame_done,
    output logic          err_oob
);

    localparam int            CW    = $clog2(FLUSH_EVERY + 1);
    localparam int            NPIX  = WIDTH * HEIGHT;
    localparam logic [XW:0]   X_LIM = (XW+1)'(WIDTH);
    localparam logic [YW:0]   Y_LIM = (YW+1)'(HEIGHT);

    sink_state_e   state_q, state_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [AW-1:0] clr_q, clr_d;
    logic          flush_q, flush_d;
    logic          err_q, err_d;
    logic          live_q;

    pix_entry_t    push_ent, pop_ent;
    logic [AW-1:0] pix_addr;
    logic          fifo_full, fifo_empty;
    logic          accept, oob, push, pop;

    assign oob      = ({1'b0, pix_x} >= X_LIM) || ({1'b0, pix_y} >= Y_LIM);
    assign accept   = pix_valid && pix_ready;
    assign push     = accept && !oob;
    assign pop      = !fifo_empty && fb_ready;
    assign pix_addr = AW'(pix_y) * AW'(WIDTH) + AW'(pix_x);
    assign push_ent = '{addr: FB_AW'(pix_addr), shade: shade_map(pix_n)};

    mandel_pix_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (sync_clk),
        .rst_n_i   (sync_rst_n),
        .push_vld_i(push),
        .push_dat_i(push_ent),
        .pop_rdy_i (pop),
        .pop_dat_o (pop_ent),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // live_q keeps pix_ready low while reset is held and for the first cycle after.
    assign pix_ready  = live_q && (state_q == ACTIVE) && !fifo_full;
    assign fb_we      = !fifo_empty || (state_q == CLEARING);
    assign fb_addr    = fifo_empty ? clr_q : AW'(pop_ent.addr);
    assign fb_data    = fifo_empty ? 8'd0 : pop_ent.shade;
    assign frame_done = (state_q == FINISHING) && fifo_empty;
    assign flush      = flush_q;
    assign err_oob    = err_q;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        fcnt_d  = fcnt_q;
        flush_d = 1'b0;
        err_d   = err_q || (accept && oob);
        case (state_q)
            ACTIVE: begin
                if (frame_finish)
                    state_d = FINISHING;
                else if (frame_clear)
                    state_d = CLEARING;
            end
            FINISHING: begin
                if (fifo_empty)
                    state_d = ACTIVE;
            end
            CLEARING: begin
                // Queued pixels go out before the blanking sweep starts.
                if (fifo_empty && fb_ready) begin
                    if (clr_q == AW'(NPIX - 1)) begin
                        clr_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        clr_d = clr_q + 1'b1;
                    end
                end
            end
            default: state_d = ACTIVE;
        endcase
        if (state_q == FINISHING) begin
            fcnt_d = '0;
        end else if (accept) begin
            if (fcnt_q == CW'(FLUSH_EVERY - 1)) begin
                fcnt_d  = '0;
                flush_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sync_clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q <= ACTIVE;
            clr_q   <= '0;
            fcnt_q  <= '0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            fcnt_q  <= fcnt_d;
            flush_q <= flush_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mandel_pixel_sink.sv
// Scoreboard bench for mandel_pixel_sink: a 200x200 instance for pixel traffic and a 4x4 instance for clear.
module tb_mandel_pixel_sink;

    localparam int W    = 200;
    localparam int H    = 200;
    localparam int MINL = 1;
    localparam int FE   = 10;
    localparam int SW   = 4;
    localparam int SH   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        pix_valid, pix_ready, frame_finish, frame_clear;
    logic [7:0]  pix_x, pix_y;
    logic [9:0]  pix_n;
    logic        fb_we, fb_ready, flush, frame_done, err_oob;
    logic [15:0] fb_addr;
    logic [7:0]  fb_data;
    logic        rdy_man, rdy_rand, rnd_rdy;
    assign fb_ready = rnd_rdy ? rdy_rand : rdy_man;

    logic        s_pix_valid, s_pix_ready, s_frame_finish, s_frame_clear;
    logic [1:0]  s_pix_x, s_pix_y;
    logic [9:0]  s_pix_n;
    logic        s_fb_we, s_fb_ready, s_flush, s_frame_done, s_err_oob;
    logic [3:0]  s_fb_addr;
    logic [7:0]  s_fb_data;

    mandel_pixel_sink u_dut (
        .sync_clk(clk), .sync_rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_n(pix_n), .frame_finish(frame_finish),
        .frame_clear(frame_clear), .fb_we(fb_we), .fb_ready(fb_ready), .fb_addr(fb_addr),
        .fb_data(fb_data), .flush(flush), .frame_done(frame_done), .err_oob(err_oob)
    );

    mandel_pixel_sink #(.WIDTH(SW), .HEIGHT(SH)) u_sml (
        .sync_clk(clk), .sync_rst_n(rst_n), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_n(s_pix_n), .frame_finish(s_frame_finish),
        .frame_clear(s_frame_clear), .fb_we(s_fb_we), .fb_ready(s_fb_ready), .fb_addr(s_fb_addr),
        .fb_data(s_fb_data), .flush(s_flush), .frame_done(s_frame_done), .err_oob(s_err_oob)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    wr_t s_exp_q[$];
    int  flush_exp_q[$];
    wr_t e_m, e_s, e_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fcnt_m = 0;
    bit err_m = 1'b0;
    bit fin_active = 1'b0;
    int fin_cyc = 0;
    int last_wr_cyc = 0;
    int flush_seen = 0;
    bit s_clr_active = 1'b0;
    bit s_chk_next = 1'b0;
    int s_clr_cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int shade_ref(input int n);
        int s;
        if (n == 0) return 0;
        if (n < MINL) return 1;
        s = n - MINL + 1;
        return (s > 255) ? 255 : s;
    endfunction

    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        rdy_rand = 1'($urandom_range(0, 1));
    end

    // Main-instance monitor: reference model on acceptance, scoreboard on framebuffer writes.
    always @(negedge clk) begin
        if (!rst_n) begin
            fin_active = 1'b0;
            exp_q.delete();
            flush_exp_q.delete();
            fcnt_m = 0;
            err_m = 1'b0;
        end else begin
            if (fin_active && cyc > fin_cyc) check("ready_in_finish", pix_ready, 0);
            if (frame_done) begin
                check("done_expected", fin_active, 1);
                check("done_cycle", cyc, ((fin_cyc > last_wr_cyc) ? fin_cyc : last_wr_cyc) + 1);
                fin_active = 1'b0;
            end
            if (fb_we && fb_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e_m = exp_q.pop_front();
                    check("wr_addr", fb_addr, e_m.addr);
                    check("wr_data", fb_data, e_m.data);
                end
                last_wr_cyc = cyc;
            end
            if (flush) begin
                flush_seen++;
                if (flush_exp_q.size() == 0) check("flush_unexpected", 1, 0);
                else check("flush_cycle", cyc, flush_exp_q.pop_front());
            end
            if (pix_valid && pix_ready) begin
                if (int'(pix_x) < W && int'(pix_y) < H) begin
                    e_m.addr = int'(pix_y) * W + int'(pix_x);
                    e_m.data = shade_ref(int'(pix_n));
                    exp_q.push_back(e_m);
                end else begin
                    err_m = 1'b1;
                end
                fcnt_m++;
                if (fcnt_m == FE) begin
                    fcnt_m = 0;
                    flush_exp_q.push_back(cyc + 1);
                end
            end
            if (frame_finish && !fin_active) begin
                fin_active = 1'b1;
                fin_cyc = cyc;
                fcnt_m = 0;
            end
        end
    end

    // Small-instance monitor: queued pixel first, then the blanking sweep over every address.
    always @(negedge clk) begin
        if (!rst_n) begin
            s_clr_active = 1'b0;
            s_chk_next = 1'b0;
            s_exp_q.delete();
        end else begin
            if (s_chk_next) begin
                check("s_ready_after_clear", s_pix_ready, 1);
                s_chk_next = 1'b0;
                s_clr_active = 1'b0;
            end else if (s_clr_active && cyc > s_clr_cyc) begin
                check("s_ready_in_clear", s_pix_ready, 0);
            end
            if (s_fb_we && s_fb_ready) begin
                if (s_exp_q.size() == 0) begin
                    check("s_unexpected_write", 1, 0);
                end else begin
                    e_s = s_exp_q.pop_front();
                    check("s_wr_addr", s_fb_addr, e_s.addr);
                    check("s_wr_data", s_fb_data, e_s.data);
                    if (s_clr_active && s_exp_q.size() == 0) s_chk_next = 1'b1;
                end
            end
            if (s_frame_clear && !s_clr_active) begin
                s_clr_active = 1'b1;
                s_clr_cyc = cyc;
                for (int i = 0; i < SW * SH; i++) begin
                    e_s.addr = i;
                    e_s.data = 0;
                    s_exp_q.push_back(e_s);
                end
            end
        end
    end

    task automatic send(input int x, input int y, input int n);
        int t;
        t = 0;
        pix_valid = 1'b1;
        pix_x = 8'(x);
        pix_y = 8'(y);
        pix_n = 10'(n);
        do begin
            @(negedge clk);
            t++;
        end while (!pix_ready && t < 300);
        if (!pix_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (fin_active && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", fin_active, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fl0;
        int t;
        int rx, ry;
        pix_valid = 0; pix_x = 0; pix_y = 0; pix_n = 0;
        frame_finish = 0; frame_clear = 0; rdy_man = 0; rnd_rdy = 0;
        s_pix_valid = 0; s_pix_x = 0; s_pix_y = 0; s_pix_n = 0;
        s_frame_finish = 0; s_frame_clear = 0; s_fb_ready = 0;

        repeat (2) @(negedge clk);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_flush", flush, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_oob", err_oob, 0);
        check("rst_s_fb_we", s_fb_we, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Shade mapping at a fixed location (addr 2*200+3).
        rdy_man = 1'b1;
        send(3, 2, 0);
        send(3, 2, 5);
        send(3, 2, 300);
        send(3, 2, 1000);
        drain();

        // Stalled write port: FIFO fills after four, head held stable.
        rdy_man = 1'b0;
        for (int i = 0; i < 4; i++) send(i * 7, 10 + i, 20 + i * 50);
        pix_valid = 1'b1; pix_x = 8'd28; pix_y = 8'd14; pix_n = 10'd220;
        repeat (5) begin
            @(negedge clk);
            e_t = exp_q[0];
            check("stall_pix_ready", pix_ready, 0);
            check("stall_fb_we", fb_we, 1);
            check("stall_fb_addr", fb_addr, e_t.addr);
            check("stall_fb_data", fb_data, e_t.data);
        end
        @(posedge clk); #1 rdy_man = 1'b1;
        send(28, 14, 220);
        drain();

        // Finish with pending writes.
        rdy_man = 1'b0;
        for (int i = 0; i < 3; i++) send(50 + i, 60, 7 + i);
        frame_finish = 1'b1;
        @(posedge clk); #1 frame_finish = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_man = 1'b1;
        wait_done();

        // Flush cadence over 25 pixels.
        fl0 = flush_seen;
        for (int i = 0; i < 25; i++) send(i * 8, 100 + i, int'($urandom_range(0, 1000)));
        drain();
        repeat (3) @(negedge clk);
        check("flush_count", flush_seen - fl0, 2);
        @(posedge clk); #1;

        // Out-of-range pixels are dropped and latch err_oob.
        send(200, 5, 7);
        send(5, 200, 3);
        repeat (3) begin
            @(negedge clk);
            check("oob_no_write", fb_we, 0);
        end
        check("err_oob_set", err_oob, 1);
        check("err_oob_model", err_oob, err_m);
        @(posedge clk); #1;

        // Random traffic with random write-port stalls.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            rx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 199));
            ry = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 199));
            send(rx, ry, int'($urandom_range(0, 1000)));
        end
        rnd_rdy = 1'b0;
        rdy_man = 1'b1;
        drain();
        check("err_oob_held", err_oob, 1);

        // Small frame: one queued pixel, then clear of all 16 addresses.
        s_pix_valid = 1'b1; s_pix_x = 2'd1; s_pix_y = 2'd2; s_pix_n = 10'd7;
        @(negedge clk);
        check("s_pix_ready", s_pix_ready, 1);
        e_t.addr = 2 * SW + 1;
        e_t.data = shade_ref(7);
        s_exp_q.push_back(e_t);
        @(posedge clk); #1 s_pix_valid = 1'b0; s_frame_clear = 1'b1;
        @(posedge clk); #1 s_frame_clear = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("s_hold_we", s_fb_we, 1);
            check("s_hold_addr", s_fb_addr, 9);
            check("s_hold_data", s_fb_data, 7);
        end
        @(posedge clk); #1 s_fb_ready = 1'b1;
        t = 0;
        while (s_clr_active && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("s_clear_timeout", s_clr_active, 0);
        check("s_queue_empty", s_exp_q.size(), 0);
        check("queue_empty", exp_q.size(), 0);
        check("flush_queue_empty", flush_exp_q.size(), 0);
        @(posedge clk); #1;

        // Reset in the middle of a clear on the main instance.
        rdy_man = 1'b0;
        frame_clear = 1'b1;
        @(posedge clk); #1 frame_clear = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("clr_fb_we", fb_we, 1);
            check("clr_fb_addr", fb_addr, 0);
            check("clr_fb_data", fb_data, 0);
            check("clr_pix_ready", pix_ready, 0);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_pix_ready", pix_ready, 0);
        check("mid_rst_fb_we", fb_we, 0);
        check("mid_rst_fb_addr", fb_addr, 0);
        check("mid_rst_fb_data", fb_data, 0);
        check("mid_rst_flush", flush, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_err_oob", err_oob, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_no_done", frame_done, 0);
            check("post_rst_no_we", fb_we, 0);
        end
        check("post_rst_pix_ready", pix_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
